waveform_readout_ctrl: RTL
==========================

// Module: waveform_readout_ctrl
// PURPOSE
//  Sequences the 32-sample waveform capture datapath and ships each captured event to the UART TX as a byte frame.
//  Qualifies discriminator triggers, fires a one-cycle capture trigger, waits out the capture window,
//  then snapshots the waveform and pulse height and streams them. Triggers arriving while busy are dropped and counted.
// PARAMETERS
//  NSAMP        32    samples per captured waveform
//  SAMP_W       14    ADC sample width (<=16)
//  HOLDOFF      64    dead cycles after frame end before re-arming
//  CAP_TIMEOUT  256   max cycles from capture trigger to end of capture window
// PORTS
//  clk            in   1             system clock
//  reset          in   1             synchronous, active-high reset
//  arm            in   1             level; 1 = accept triggers, 0 = disarm after current frame
//  trig_in        in   1             discriminator trigger, rising edge qualifies
//  cap_trigger    out  1             one-cycle pulse to the capture datapath
//  cap_window     in   1             capture datapath long-trigger (capture window active)
//  waveform       in   NSAMP*SAMP_W  captured samples, sample 0 in LSBs
//  pulse_height   in   32            pulse height from capture datapath
//  tx_data        out  8             byte to UART TX
//  tx_valid       out  1             tx_data valid
//  tx_ready       in   1             UART TX accepts byte when tx_valid && tx_ready
//  busy           out  1             1 in every state except IDLE/ARMED
//  frame_count    out  16            frames fully sent, wraps 0xFFFF->0
//  drop_count     out  16            trigger edges ignored while busy, saturates at 0xFFFF
//  timeout_err    out  1             sticky; set on capture timeout, cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; snapshot regs 0; trig_in edge detector history cleared.
//  States: IDLE -> ARMED when arm=1. ARMED -> IDLE when arm=0.
//   ARMED: rising edge of trig_in -> assert cap_trigger for exactly 1 cycle, go CAPTURE.
//   CAPTURE: wait for cap_window 1 then 0 (falling edge); on fall go SNAP.
//    If CAP_TIMEOUT cycles elapse since cap_trigger without a fall: set timeout_err, go HOLDOFF, no frame sent.
//   SNAP (1 cycle): register waveform and pulse_height into local snapshot; byte index=0; go SEND.
//   SEND: present frame bytes in order; index advances only on tx_valid && tx_ready.
//    tx_data/tx_valid held stable while tx_valid && !tx_ready. After last byte accepted: frame_count++, go HOLDOFF.
//   HOLDOFF: count HOLDOFF cycles, then ARMED if arm=1 else IDLE.
//  Frame (MSB first): 0xA5 sync; frame_count[7:0]; pulse_height[31:24..7:0] (4 bytes);
//   then per sample 0..NSAMP-1: {zero-pad to 16 bits}[15:8], [7:0]. Default length 2+4+64 = 70 bytes.
//  Trigger edge detect: registered trig_in; edge = trig_in && !trig_d. Level-high trig_in never retriggers.
//  drop_count increments on each qualified edge in CAPTURE/SNAP/SEND/HOLDOFF or when arm=0; saturates.
//  Edge in the same cycle ARMED is entered from HOLDOFF: accepted (not dropped).
//  arm falling mid-frame: current frame completes; controller then goes IDLE after HOLDOFF.
//  reset mid-SEND: tx_valid drops the next cycle; partial frame is abandoned (receiver resyncs on 0xA5).
//  cap_trigger latency: 1 cycle after the trig_in edge cycle (registered output).
// CONFIGURATION
//  READOUT_CHECKSUM_EN defined: one extra trailing byte = XOR of all preceding frame bytes incl. 0xA5;
//   frame length 71. Not defined: no checksum byte, frame length 70, XOR logic absent.
// STRUCTURE
//  Package waveform_readout_pkg: state enum (IDLE, ARMED, CAPTURE, SNAP, SEND, HOLDOFF),
//   FRAME_SYNC=8'hA5, FRAME_HDR_BYTES=6, frame-length function of NSAMP and checksum macro.
//  Sub-module frame_byte_sel: combinational mux, byte index + snapshot -> tx_data (header/payload/checksum select).
//  FSM, counters, snapshot registers and handshake stay in waveform_readout_ctrl.
// TESTING
//  arm=1, one trig_in edge, cap_window high 32 cycles, tx_ready=1 -> cap_trigger 1 pulse; 70 bytes, first A5 00; frame_count=1.
//  waveform sample0=0x3FFF, pulse_height=0x01020304 -> bytes 3..6 = 01 02 03 04, bytes 7..8 = 3F FF.
//  tx_ready toggled 1-of-3 cycles -> tx_data stable while stalled; byte sequence identical to tx_ready=1 run.
//  5 trig_in edges during SEND and HOLDOFF -> drop_count=5, exactly one frame sent, no second cap_trigger.
//  cap_window never falls -> after 256 cycles timeout_err=1, no tx_valid, ARMED again after 64 HOLDOFF cycles.
//  reset asserted at byte 20 -> tx_valid=0 next cycle, all counters 0; with READOUT_CHECKSUM_EN: 71st byte = XOR of prior 70.

Source files
------------

// File: rtl/waveform_readout_pkg.sv
// Shared types and frame-layout helpers for the waveform readout controller.
// Checksum byte presence is selected by READOUT_CHECKSUM_EN.
package waveform_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SNAP    = 3'd3,
    ST_SEND    = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_e;

  localparam logic [7:0] FRAME_SYNC      = 8'hA5;
  localparam int         FRAME_HDR_BYTES = 6;

`ifdef READOUT_CHECKSUM_EN
  localparam int FRAME_CSUM_BYTES = 1;
`else
  localparam int FRAME_CSUM_BYTES = 0;
`endif

  // Sync + count + 4 pulse-height bytes, two bytes per sample, optional XOR trailer.
  function automatic int frame_len(input int nsamp);
    return FRAME_HDR_BYTES + 2 * nsamp + FRAME_CSUM_BYTES;
  endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// frame_byte_sel: maps a frame byte index onto header, sample payload or XOR trailer (READOUT_CHECKSUM_EN).
// Latency: purely combinational.
// Backpressure: none; the caller holds byte_idx and the snapshot stable while stalled.
module frame_byte_sel
  import waveform_readout_pkg::*;
#(
  parameter int NSAMP  = 32,
  parameter int SAMP_W = 14,
  parameter int IDX_W  = 7
) (
  input  logic [IDX_W-1:0]        byte_idx,
  input  logic [7:0]              frame_cnt,
  input  logic [31:0]             pulse_height,
  input  logic [NSAMP*SAMP_W-1:0] waveform,
  output logic [7:0]              byte_dat
);

  localparam int FLEN = frame_len(NSAMP);

  logic [7:0] frame [FLEN];
`ifdef READOUT_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_comb begin
    frame[0] = FRAME_SYNC;
    frame[1] = frame_cnt;
    frame[2] = pulse_height[31:24];
    frame[3] = pulse_height[23:16];
    frame[4] = pulse_height[15:8];
    frame[5] = pulse_height[7:0];
    // Samples are zero-extended to 16 bits and sent high byte first.
    for (int k = 0; k < NSAMP; k++) begin
      frame[FRAME_HDR_BYTES + 2*k]     = 8'(16'(waveform[k*SAMP_W +: SAMP_W]) >> 8);
      frame[FRAME_HDR_BYTES + 2*k + 1] = 8'(16'(waveform[k*SAMP_W +: SAMP_W]));
    end
`ifdef READOUT_CHECKSUM_EN
    csum = 8'h00;
    for (int i = 0; i < FLEN - 1; i++) begin
      csum = csum ^ frame[i];
    end
    frame[FLEN-1] = csum;
`endif
    byte_dat = 8'h00;
    if (int'(byte_idx) < FLEN) begin
      byte_dat = frame[byte_idx];
    end
  end

endmodule

// File: rtl/waveform_readout_ctrl.sv
// waveform_readout_ctrl: qualify trigger, fire capture, wait window, snapshot, stream frame to UART TX (READOUT_CHECKSUM_EN adds XOR byte).
// Latency: cap_trigger 1 cycle after the trig_in edge; first byte 2 cycles after cap_window fall is sampled.
// Backpressure: tx_valid/tx_ready, byte held while stalled; triggers while busy are dropped and counted.
module waveform_readout_ctrl
  import waveform_readout_pkg::*;
#(
  parameter int NSAMP       = 32,
  parameter int SAMP_W      = 14,
  parameter int HOLDOFF     = 64,
  parameter int CAP_TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    trig_in,
  output logic                    cap_trigger,
  input  logic                    cap_window,
  input  logic [NSAMP*SAMP_W-1:0] waveform,
  input  logic [31:0]             pulse_height,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [15:0]             frame_count,
  output logic [15:0]             drop_count,
  output logic                    timeout_err
);

  localparam int FLEN    = frame_len(NSAMP);
  localparam int IDX_W   = $clog2(FLEN);
  localparam int CNT_MAX = (CAP_TIMEOUT > HOLDOFF) ? CAP_TIMEOUT : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic                    trig_d_q;
  logic                    win_seen_q, win_seen_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NSAMP*SAMP_W-1:0] wave_q, wave_d;
  logic [31:0]             ph_q, ph_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic [15:0]             drop_count_q, drop_count_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    cap_trigger_q, cap_trigger_d;
  logic                    trig_edge;
  logic                    drop;
  logic [7:0]              sel_byte;

  assign trig_edge = trig_in && !trig_d_q;

  always_comb begin
    state_d       = state_q;
    win_seen_d    = win_seen_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    wave_d        = wave_q;
    ph_d          = ph_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    timeout_err_d = timeout_err_q;
    cap_trigger_d = 1'b0;
    drop          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        drop = trig_edge && !arm;
        if (arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
          drop    = trig_edge;
        end else if (trig_edge) begin
          state_d       = ST_CAPTURE;
          cap_trigger_d = 1'b1;
          cnt_d         = '0;
          win_seen_d    = 1'b0;
        end
      end
      ST_CAPTURE: begin
        drop = trig_edge;
        if (cap_window) begin
          win_seen_d = 1'b1;
        end
        // A fall on the final timeout cycle still counts as a good capture.
        if (win_seen_q && !cap_window) begin
          state_d = ST_SNAP;
        end else if (cnt_q == CNT_W'(CAP_TIMEOUT - 1)) begin
          state_d       = ST_HOLDOFF;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SNAP: begin
        drop    = trig_edge;
        wave_d  = waveform;
        ph_d    = pulse_height;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        drop = trig_edge;
        if (tx_ready) begin
          if (idx_q == IDX_W'(FLEN - 1)) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_HOLDOFF;
            cnt_d         = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        // The cycle that re-arms also accepts an edge, so it is not lost to the transition.
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          if (!arm) begin
            state_d = ST_IDLE;
            drop    = trig_edge;
          end else if (trig_edge) begin
            state_d       = ST_CAPTURE;
            cap_trigger_d = 1'b1;
            cnt_d         = '0;
            win_seen_d    = 1'b0;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          drop  = trig_edge;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      trig_d_q      <= 1'b0;
      win_seen_q    <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      wave_q        <= '0;
      ph_q          <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      timeout_err_q <= 1'b0;
      cap_trigger_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_d_q      <= trig_in;
      win_seen_q    <= win_seen_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wave_q        <= wave_d;
      ph_q          <= ph_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      timeout_err_q <= timeout_err_d;
      cap_trigger_q <= cap_trigger_d;
    end
  end

  frame_byte_sel #(
    .NSAMP  (NSAMP),
    .SAMP_W (SAMP_W),
    .IDX_W  (IDX_W)
  ) u_frame_byte_sel (
    .byte_idx     (idx_q),
    .frame_cnt    (frame_count_q[7:0]),
    .pulse_height (ph_q),
    .waveform     (wave_q),
    .byte_dat     (sel_byte)
  );

  assign tx_valid    = (state_q == ST_SEND);
  assign tx_data     = tx_valid ? sel_byte : 8'h00;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ARMED);
  assign cap_trigger = cap_trigger_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign timeout_err = timeout_err_q;

endmodule
